instruction_fetch_stage: RTL

- IF stage of the mips_16 pipeline.
- Owns the PC register and drives `pc` into the instruction ROM. Samples the ROM's asynchronous 16-bit `instruction` back in the same cycle.
- Captures fetched instruction and PC+1 into the IF/ID pipeline register for the decode stage.
- Handles decode/hazard stall, branch redirect and flush, and a one-cycle boot bubble after reset.

---
 rtl/instruction_fetch_stage_pkg.sv | 17 +
 rtl/instruction_fetch_stage_if_id_register.sv | 40 ++++
 rtl/instruction_fetch_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the mips_16 instruction fetch stage: default widths,
// the bubble encoding and the IF state encodings.
package instruction_fetch_stage_pkg;

    localparam int              PC_WIDTH_DEF         = 8;
    localparam int              INSTR_MEM_ADDR_WIDTH = 8;
    localparam int              INSTR_WIDTH_DEF      = 16;
    localparam logic [15:0]     NOP_INSTR_DEF        = 16'h0000;

    // IF stage controller states.
    typedef enum logic [1:0] {
        IF_BOOT     = 2'b00,
        IF_RUN      = 2'b01,
        IF_REDIRECT = 2'b10
    } if_state_e;

endpackage

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register: captures PC+1, the fetched instruction and a valid
// flag. Flush (bubble insertion) has priority over load; neither means hold.
module instruction_fetch_stage_if_id_register #(
    parameter int                     PC_WIDTH    = 8,
    parameter int                     INSTR_WIDTH = 16,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   flush,
    input  logic [PC_WIDTH-1:0]    pc_in,
    input  logic [INSTR_WIDTH-1:0] instruction_in,
    output logic [PC_WIDTH-1:0]    if_id_pc,
    output logic [INSTR_WIDTH-1:0] if_id_instruction,
    output logic                   if_id_valid
);

    logic [PC_WIDTH-1:0]    pc_reg;
    logic [INSTR_WIDTH-1:0] instr_reg;
    logic                   valid_reg;

    // Register update: reset/flush load a bubble, load captures, else hold.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pc_reg    <= '0;
            instr_reg <= NOP_INSTR;
            valid_reg <= 1'b0;
        end else if (load) begin
            pc_reg    <= pc_in;
            instr_reg <= instruction_in;
            valid_reg <= 1'b1;
        end
    end

    assign if_id_pc          = pc_reg;
    assign if_id_instruction = instr_reg;
    assign if_id_valid       = valid_reg;

endmodule

// File: rtl/instruction_fetch_stage.sv
// mips_16 IF stage: PC register, boot/run/redirect controller and IF/ID
// register. Optional performance counters are enabled with IF_PERF_CNT_EN.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter int                     PC_WIDTH    = PC_WIDTH_DEF,
    parameter int                     INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(NOP_INSTR_DEF)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic [PC_WIDTH-1:0]    pc,
    input  logic [INSTR_WIDTH-1:0] instruction_in,
    output logic [PC_WIDTH-1:0]    if_id_pc,
    output logic [INSTR_WIDTH-1:0] if_id_instruction,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]            fetch_count,
    output logic [31:0]            stall_count,
`endif
    output logic                   if_id_valid
);

    if_state_e           state_reg, state_next;
    logic [PC_WIDTH-1:0] pc_reg, pc_next;
    logic [PC_WIDTH-1:0] pc_plus_one;
    logic                load, flush;

    // PC+1 wraps naturally at 2^PC_WIDTH.
    assign pc_plus_one = pc_reg + PC_WIDTH'(1);

    // State and PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IF_BOOT;
            pc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    // Next-state, next-PC and IF/ID controls. Redirect behaves like run once
    // the bubble is in place: a new branch re-targets, stall holds, otherwise
    // the target instruction is captured and normal fetch resumes.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        load       = 1'b0;
        flush      = 1'b0;
        case (state_reg)
            IF_BOOT: begin
                flush      = 1'b1;
                state_next = IF_RUN;
            end
            IF_RUN, IF_REDIRECT: begin
                if (branch_taken) begin
                    pc_next    = branch_target;
                    flush      = 1'b1;
                    state_next = IF_REDIRECT;
                end else if (!stall) begin
                    pc_next    = pc_plus_one;
                    load       = 1'b1;
                    state_next = IF_RUN;
                end
            end
            default: begin
                state_next = IF_BOOT;
            end
        endcase
    end

    assign pc = pc_reg;

    instruction_fetch_stage_if_id_register #(
        .PC_WIDTH   (PC_WIDTH),
        .INSTR_WIDTH(INSTR_WIDTH),
        .NOP_INSTR  (NOP_INSTR)
    ) u_if_id (
        .clk              (clk),
        .rst              (rst),
        .load             (load),
        .flush            (flush),
        .pc_in            (pc_plus_one),
        .instruction_in   (instruction_in),
        .if_id_pc         (if_id_pc),
        .if_id_instruction(if_id_instruction),
        .if_id_valid      (if_id_valid)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count_reg, stall_count_reg;

    // Counters: valid captures, and stalled cycles outside BOOT.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_reg <= '0;
            stall_count_reg <= '0;
        end else begin
            if (load)
                fetch_count_reg <= fetch_count_reg + 32'd1;
            if (stall && (state_reg != IF_BOOT))
                stall_count_reg <= stall_count_reg + 32'd1;
        end
    end

    assign fetch_count = fetch_count_reg;
    assign stall_count = stall_count_reg;
`endif

endmodule
